// File: rtl/seq_control_unit.sv
// seq_control_unit: multi-cycle fetch/decode/execute sequencer for the
// 24-bit-instruction, 16-bit-data processor.
//
// Flow: IDLE -> FETCH -> LOAD -> DECODE -> {EXEC | MEM [-> WB] | JUMP retire}
// followed by an instruction-boundary check that either fetches the next
// instruction or returns to IDLE.
//
// All outputs come from registers (state, pc, err, retired, mem_wr), so
// there is no combinational path from any input to any output.
//
// Optional feature macro: SEQ_SINGLE_STEP_EN
//   defined   -> every boundary returns to IDLE, so one run pulse executes
//                exactly one instruction.
//   undefined -> continuous execution until stop is seen at a boundary.

module seq_control_unit #(
    parameter int PC_W        = 6,
    parameter int MEM_TIMEOUT = 16   // 1..255 cycles in MEM before abort
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            stop,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    output logic            ir_load,
    input  logic [3:0]      opcode,
    input  logic [5:0]      jmp_addrs,
    output logic            alu_en,
    output logic            rf_we,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            err,
    output logic [15:0]     retired
);

    localparam logic [3:0] OP_RED  = 4'b1101;
    localparam logic [3:0] OP_WRT  = 4'b1110;
    localparam logic [3:0] OP_JUMP = 4'b1111;

    // Last MEM cycle index before the timeout abort fires.
    localparam logic [7:0] MEM_CNT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t          state;
    state_t          state_nx;
    state_t          boundary_nx;
    logic            mem_wr;      // captured in DECODE: 1 = WRT, 0 = RED
    logic [7:0]      mem_cnt;     // cycles already spent in MEM
    logic            pc_inc;
    logic            pc_jump;
    logic            retire;
    logic            set_err;
    logic            clr_err;
    logic [PC_W-1:0] jmp_pc;

    assign jmp_pc = PC_W'(jmp_addrs);

    // Where an instruction boundary goes next.
`ifdef SEQ_SINGLE_STEP_EN
    assign boundary_nx = S_IDLE;
`else
    assign boundary_nx = stop ? S_IDLE : S_FETCH;
`endif

    // Next-state and datapath-control decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves a value unassigned; a missing default here infers a latch.
        state_nx = state;
        pc_inc   = 1'b0;
        pc_jump  = 1'b0;
        retire   = 1'b0;
        set_err  = 1'b0;
        clr_err  = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nx = S_FETCH;
                    clr_err  = 1'b1;
                end
            end
            S_FETCH: begin
                if (imem_valid) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OP_JUMP) begin
                    pc_jump  = 1'b1;
                    retire   = 1'b1;
                    state_nx = boundary_nx;
                end else if (opcode == OP_RED || opcode == OP_WRT) begin
                    state_nx = S_MEM;
                end else begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_inc   = 1'b1;
                retire   = 1'b1;
                state_nx = boundary_nx;
            end
            S_MEM: begin
                // An ack on the final allowed cycle still completes normally.
                if (dmem_ack) begin
                    if (mem_wr) begin
                        pc_inc   = 1'b1;
                        retire   = 1'b1;
                        state_nx = boundary_nx;
                    end else begin
                        state_nx = S_WB;
                    end
                end else if (mem_cnt == MEM_CNT_LAST) begin
                    set_err  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_WB: begin
                pc_inc   = 1'b1;
                retire   = 1'b1;
                state_nx = boundary_nx;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State register; reset drops every strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Program counter, retired-instruction count and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= '0;
            retired <= '0;
            err     <= 1'b0;
        end else begin
            if (pc_jump) begin
                pc <= jmp_pc;
            end else if (pc_inc) begin
                pc <= pc + PC_W'(1);
            end
            if (retire) begin
                retired <= retired + 16'd1;
            end
            if (set_err) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

    // Memory-access direction capture and MEM-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr  <= 1'b0;
            mem_cnt <= '0;
        end else begin
            if (state == S_DECODE) begin
                mem_wr <= (opcode == OP_WRT);
            end
            if (state == S_MEM) begin
                mem_cnt <= mem_cnt + 8'd1;
            end else begin
                mem_cnt <= '0;
            end
        end
    end

    // Strobes decoded purely from registered state.
    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign ir_load   = (state == S_LOAD);
    assign alu_en    = (state == S_EXEC);
    assign rf_we     = (state == S_EXEC) || (state == S_WB);
    assign dmem_req  = (state == S_MEM);
    assign dmem_we   = (state == S_MEM) && mem_wr;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_seq_control_unit.sv
// tb_seq_control_unit: table-driven single-instruction vectors checked
// through a scoreboard queue, plus hand-written sequences for the
// self-targeted JUMP loop and reset in the middle of a MEM access.
// Honours SEQ_SINGLE_STEP_EN the same way the design does.

module tb_seq_control_unit;

    localparam int PC_W        = 6;
    localparam int MEM_TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            run;
    logic            stop;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic            ir_load;
    logic [3:0]      opcode;
    logic [5:0]      jmp_addrs;
    logic            alu_en;
    logic            rf_we;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ack;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            err;
    logic [15:0]     retired;

    seq_control_unit #(.PC_W(PC_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .stop      (stop),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_valid(imem_valid),
        .ir_load   (ir_load),
        .opcode    (opcode),
        .jmp_addrs (jmp_addrs),
        .alu_en    (alu_en),
        .rf_we     (rf_we),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ack  (dmem_ack),
        .pc        (pc),
        .busy      (busy),
        .err       (err),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [5:0] jmp;
        int         fw;       // extra FETCH cycles before imem_valid
        int         d;        // MEM cycle on which ack arrives, 0 = never
        int         exp_pc;
        int         exp_ret;
        int         exp_err;
    } vec_t;

    typedef struct {
        int pc, ret, err, ir, alu, rf, dreq, dwe, busy, faddr;
    } exp_t;

    vec_t vecs [14];
    exp_t sb_q [$];

    logic [9:0] prog [64];     // {opcode, jmp} per program address
    int fetch_wait, ack_delay;
    int fcnt, mcnt;
    int n_busy, n_ir, n_alu, n_rf, n_dreq, n_dwe;
    bit seen_fetch;
    int first_addr;
    int cur_pc;
    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Memory models, IR model and strobe monitor, all on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            fcnt = 0; mcnt = 0; imem_valid = 1'b0; dmem_ack = 1'b0;
        end else begin
            if (imem_req) begin
                fcnt++;
                imem_valid = (fcnt > fetch_wait);
                if (!seen_fetch) begin
                    seen_fetch = 1'b1;
                    first_addr = int'(imem_addr);
                end
            end else begin
                fcnt = 0;
                imem_valid = 1'b0;
            end
            if (dmem_req) begin
                mcnt++;
                dmem_ack = (ack_delay != 0) && (mcnt == ack_delay);
            end else begin
                mcnt = 0;
                dmem_ack = 1'b0;
            end
            if (ir_load) {opcode, jmp_addrs} = prog[imem_addr];
            if (busy)     n_busy++;
            if (ir_load)  n_ir++;
            if (alu_en)   n_alu++;
            if (rf_we)    n_rf++;
            if (dmem_req) n_dreq++;
            if (dmem_we)  n_dwe++;
        end
    end

    task automatic clear_counts();
        n_busy = 0; n_ir = 0; n_alu = 0; n_rf = 0; n_dreq = 0; n_dwe = 0;
        seen_fetch = 1'b0; first_addr = -1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Strobe counts and latency for one instruction, derived from opcode.
    function automatic exp_t model(input vec_t v, input int start_pc);
        exp_t e;
        bit jmp, red, wrt, mem, tmo;
        jmp = (v.op == 4'd15);
        red = (v.op == 4'd13);
        wrt = (v.op == 4'd14);
        mem = red || wrt;
        tmo = mem && (v.d == 0);
        e.pc    = v.exp_pc;
        e.ret   = v.exp_ret;
        e.err   = v.exp_err;
        e.ir    = 1;
        e.alu   = (!mem && !jmp) ? 1 : 0;
        e.dreq  = mem ? (tmo ? MEM_TIMEOUT : v.d) : 0;
        e.dwe   = wrt ? e.dreq : 0;
        e.rf    = e.alu + ((red && !tmo) ? 1 : 0);
        e.busy  = jmp ? 3 + v.fw
                : mem ? 3 + v.fw + e.dreq + ((red && !tmo) ? 1 : 0)
                : 4 + v.fw;
        e.faddr = start_pc;
        return e;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        bit   ok;
        prog[cur_pc] = {v.op, v.jmp};
        fetch_wait   = v.fw;
        ack_delay    = v.d;
        sb_q.push_back(model(v, cur_pc));
        clear_counts();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        wait_idle(100, ok);
        check($sformatf("v%0d_done", idx), int'(ok), 1);
        e = sb_q.pop_front();
        check($sformatf("v%0d_pc", idx),      int'(pc),      e.pc);
        check($sformatf("v%0d_retired", idx), int'(retired), e.ret);
        check($sformatf("v%0d_err", idx),     int'(err),     e.err);
        check($sformatf("v%0d_ir_load", idx), n_ir,          e.ir);
        check($sformatf("v%0d_alu_en", idx),  n_alu,         e.alu);
        check($sformatf("v%0d_rf_we", idx),   n_rf,          e.rf);
        check($sformatf("v%0d_dmem_req", idx), n_dreq,       e.dreq);
        check($sformatf("v%0d_dmem_we", idx), n_dwe,         e.dwe);
        check($sformatf("v%0d_busy_cyc", idx), n_busy,      e.busy);
        check($sformatf("v%0d_fetch_addr", idx), first_addr, e.faddr);
        cur_pc = e.pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   ok;
        int   ret0;

        //            op     jmp    fw d  pc  ret err
        vecs[0]  = '{4'd1,  6'd0,  0, 0, 1,  1,  0};  // ADD
        vecs[1]  = '{4'd2,  6'd0,  2, 0, 2,  2,  0};  // SUB, slow fetch
        vecs[2]  = '{4'd12, 6'd0,  1, 0, 3,  3,  0};  // INC
        vecs[3]  = '{4'd15, 6'd5,  0, 0, 5,  4,  0};  // JUMP 5
        vecs[4]  = '{4'd13, 6'd0,  0, 3, 6,  5,  0};  // RED at pc 5, ack 3
        vecs[5]  = '{4'd14, 6'd0,  0, 2, 7,  6,  0};  // WRT, ack 2
        vecs[6]  = '{4'd14, 6'd0,  0, 0, 7,  6,  1};  // WRT timeout
        vecs[7]  = '{4'd0,  6'd0,  0, 0, 8,  7,  0};  // next run clears err
        vecs[8]  = '{4'd15, 6'd63, 0, 0, 63, 8,  0};  // JUMP 63
        vecs[9]  = '{4'd12, 6'd0,  0, 0, 0,  9,  0};  // INC at 63 wraps
        vecs[10] = '{4'd13, 6'd0,  0, 1, 1,  10, 0};  // RED, ack first cycle
        vecs[11] = '{4'd15, 6'd42, 0, 0, 42, 11, 0};  // JUMP 42
        vecs[12] = '{4'd13, 6'd0,  2, 0, 42, 11, 1};  // RED timeout
        vecs[13] = '{4'd3,  6'd0,  0, 0, 43, 12, 0};  // MUL

        for (int i = 0; i < 64; i++) prog[i] = '0;
        run = 1'b0; stop = 1'b1; opcode = '0; jmp_addrs = '0;
        fetch_wait = 0; ack_delay = 0; cur_pc = 0;
        imem_valid = 1'b0; dmem_ack = 1'b0;
        clear_counts();

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",     int'(busy),     0);
        check("rst_strobes",  int'({imem_req, ir_load, alu_en, rf_we, dmem_req, dmem_we}), 0);
        check("rst_pc",       int'(pc),       0);
        check("rst_err",      int'(err),      0);
        check("rst_retired",  int'(retired),  0);
        rst_n = 1'b1;
        @(negedge clk);

        // One instruction per run pulse; stop held high so each returns to IDLE.
        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], i);
            @(negedge clk);
            check($sformatf("v%0d_idle_gap", i), int'(busy), 0);
        end

        // Self-targeted JUMP.
        ret0 = int'(retired);
        prog[cur_pc] = {4'd15, 6'(cur_pc)};
        fetch_wait = 0;
        stop = 1'b0;
        clear_counts();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
`ifndef SEQ_SINGLE_STEP_EN
        repeat (30) @(negedge clk);
        check("selfjump_looping", int'(busy), 1);
        run = 1'b1;                       // ignored while busy
        @(negedge clk);
        run = 1'b0;
        stop = 1'b1;
        wait_idle(20, ok);
        check("selfjump_stopped", int'(ok), 1);
        check("selfjump_many",    int'(n_ir >= 5), 1);
        check("selfjump_retired", int'(retired), ret0 + n_ir);
`else
        wait_idle(20, ok);
        check("step_selfjump_idle", int'(ok), 1);
        check("step_selfjump_retired", int'(retired), ret0 + 1);
        stop = 1'b1;
`endif
        check("selfjump_pc",  int'(pc), cur_pc);
        check("selfjump_alu", n_alu + n_rf, 0);

        // Reset while a RED waits in MEM.
        prog[cur_pc] = {4'd13, 6'd0};
        ack_delay = 0;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = dmem_req;
        end
        check("mid_mem_reached", int'(ok), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_dmem_req", int'(dmem_req), 0);
        check("mid_rst_busy",     int'(busy),     0);
        check("mid_rst_pc",       int'(pc),       0);
        check("mid_rst_retired",  int'(retired),  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal operation resumes from pc 0.
        cur_pc = 0;
        v = '{4'd1, 6'd0, 0, 0, 1, 1, 0};
        run_vec(v, 99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/seq_control_unit.md
Name: seq_control_unit

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 24-bit-instruction, 16-bit-data processor.
- Drives the instruction memory fetch handshake and the instruction-register load strobe.
- Reads the registered opcode back from the IR and sequences ALU/register-file writes, data-memory RED/WRT handshakes, JUMP and PC update.
- Sits between program memory, the instruction register, the ALU/register file and data memory.

Parameters:
PC_W, 6, program counter width; matches the 6-bit jump address field; PC wraps modulo 2^PC_W.
MEM_TIMEOUT, 16, max cycles in MEM waiting for dmem_ack before abort; range 1..255.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
run  input  1  start/resume; sampled only in IDLE.
stop  input  1  halt request; sampled at instruction boundary.
imem_req  output  1  fetch request; high throughout FETCH.
imem_addr  output  PC_W  fetch address, equals pc.
imem_valid  input  1  instruction word on program-memory bus is valid.
ir_load  output  1  one-cycle strobe: IR captures the instruction word.
opcode  input  4  registered opcode from the IR.
jmp_addrs  input  6  registered jump target from the IR.
alu_en  output  1  ALU evaluate strobe, one cycle.
rf_we  output  1  register-file write strobe to rz, one cycle.
dmem_req  output  1  data-memory request; high throughout MEM.
dmem_we  output  1  1 = WRT, 0 = RED; valid while dmem_req=1.
dmem_ack  input  1  data-memory completion.
pc  output  PC_W  current program counter.
busy  output  1  high in every state except IDLE.
err  output  1  sticky memory-timeout flag.
retired  output  16  count of completed instructions; wraps at 65535 to 0.

Behaviour:
- Async reset (rst_n=0): state=IDLE; pc=0, err=0, retired=0. All strobes (imem_req, ir_load, alu_en, rf_we, dmem_req, dmem_we) =0; busy=0.
- All outputs are registers or decoded from the state register only. No combinational input-to-output paths.
- IDLE: run=1 -> FETCH. On entering FETCH from IDLE, err clears.
- FETCH: imem_req=1 and imem_addr=pc. Stays until imem_valid=1, then -> LOAD. No fetch timeout.
- LOAD: ir_load=1 for exactly one cycle -> DECODE.
- DECODE: opcode and jmp_addrs are valid this cycle. Routing:
  - opcode 0000-1100 -> EXEC.
  - 1101 (RED) and 1110 (WRT) -> MEM.
  - 1111 (JUMP): pc <= jmp_addrs zero-extended/truncated to PC_W, retired += 1, then boundary check.
- EXEC: alu_en=1, rf_we=1 for one cycle. pc <= pc+1 (wraps), retired += 1, then boundary check. Latency for ALU ops is 4 cycles plus fetch wait.
- MEM: dmem_req=1, dmem_we=(opcode==1110). A cycle counter starts at 0.
  - dmem_ack=1 with RED -> WB.
  - dmem_ack=1 with WRT: pc+1, retired += 1, boundary check.
  - Counter reaches MEM_TIMEOUT with no ack: err=1, dmem_req drops, -> IDLE. pc and retired are unchanged.
- WB: rf_we=1 for one cycle. pc+1, retired += 1, boundary check.
- Boundary check:
  - stop=1 -> IDLE.
  - Otherwise -> FETCH.
  - stop and run both high: stop wins.
  - stop outside a boundary is ignored until the next boundary.
- run while busy is ignored.
- A self-targeted JUMP loops indefinitely until stop.
- pc wrap: pc=2^PC_W-1 followed by +1 gives 0.
- Mid-operation reset aborts immediately. dmem_req and imem_req drop asynchronously.

Optional Feature:
SEQ_SINGLE_STEP_EN
- Defined: every boundary check returns to IDLE regardless of stop, so each run pulse executes exactly one instruction. busy falls the cycle after retirement.
- Undefined: continuous execution as above.

Test Plan:
- Reset, run=1 one cycle, imem_valid immediate, ADD (opcode 0001) -> imem_req in cycle 1, ir_load cycle 2, alu_en and rf_we single cycle in cycle 4; pc 0->1; retired=1.
- RED at pc=5 with dmem_ack after 3 cycles -> dmem_req high 3 cycles, dmem_we=0, rf_we one cycle in WB, pc=6. WRT -> dmem_we=1, no rf_we.
- JUMP jmp_addrs=6'd42 -> pc=42, next imem_addr=42, no alu_en/rf_we. Self-jump with stop raised -> IDLE after the current JUMP retires.
- WRT with dmem_ack never asserted, MEM_TIMEOUT=16 -> err=1 after 16 MEM cycles, IDLE, pc unchanged. Next run clears err.
- pc=63 executing an INC -> pc wraps to 0. Assert rst_n=0 during MEM -> dmem_req=0 immediately, pc=0, retired=0.
- With SEQ_SINGLE_STEP_EN, three run pulses over ADD, SUB, MUL -> retired=3, busy low between pulses, pc=3.
